uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface between N_REQ requesters using round-robin arbitration with message locking.
- The winning requester owns the transmitter until it delivers a byte flagged last, or until it goes idle for IDLE_TIMEOUT cycles.
- Sits between the firmware/debug byte sources and the single uart_tx instance.
- Bytes from different requesters never interleave inside a message.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- IDLE_TIMEOUT, 1024: cycles with owner valid low, while locked, before forced release. 0 disables the timeout.
- TO_WIDTH, $clog2(IDLE_TIMEOUT+1): width of the timeout counter (derived).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_data  in  N_REQ*8  requester bytes; requester k occupies bits [8k+7:8k]
- i_req_valid  in  N_REQ  per-requester byte valid
- i_req_last  in  N_REQ  per-requester flag: this byte ends the message
- o_req_ready  out  N_REQ  per-requester ready; a byte transfers when valid & ready
- o_grant  out  N_REQ  one-hot current owner; all-zero when idle
- o_tx_data  out  8  byte to uart_tx
- o_tx_valid  out  1  valid to uart_tx
- i_tx_ready  in  1  ready from uart_tx
- o_busy  out  1  high while locked to an owner

Behaviour:
- Reset (async assert, sync deassert in the design):
  - State IDLE; owner=0; last_owner=N_REQ-1, so requester 0 has first priority.
  - Timeout counter=0.
  - o_grant=0, o_busy=0, o_tx_valid=0, o_req_ready=0, o_tx_data=0.
  - Reset mid-message drops the lock immediately. The byte already accepted by uart_tx is its own concern.
- States: IDLE, LOCKED.
- IDLE:
  - o_tx_valid=0; all o_req_ready=0.
  - If any i_req_valid bit is set, choose the first set bit searching from last_owner+1 upward, wrapping modulo N_REQ.
  - Register that bit as owner and go to LOCKED.
  - Arbitration latency is 1 cycle; no byte transfers in the decision cycle.
- LOCKED:
  - o_grant=onehot(owner); o_busy=1.
  - o_tx_data = owner's data slice; o_tx_valid = i_req_valid[owner]. Both are combinational from owner.
  - o_req_ready[owner] = i_tx_ready; all other ready bits are 0.
  - Handshake = i_req_valid[owner] & i_tx_ready.
  - Handshake with i_req_last[owner]=1: go to IDLE, last_owner<=owner, counter<=0. Re-arbitration happens in the next IDLE cycle, so other requesters get a turn first.
- Timeout (only when IDLE_TIMEOUT>0):
  - Counter clears on any cycle where i_req_valid[owner]=1 (waiting on i_tx_ready does not count as idle).
  - Counter increments on each LOCKED cycle with owner valid low.
  - When the counter reaches IDLE_TIMEOUT and valid is still low: go to IDLE, last_owner<=owner, counter<=0.
  - If owner valid rises on the same cycle the counter hits the limit, valid wins: stay LOCKED and clear the counter.
- Non-owner valids are ignored while LOCKED. They must hold until granted; ready stays 0 for them.
- Owner deasserting valid mid-message keeps the lock; only last or timeout releases it.
- Single requester repeatedly requesting: after release it wins again on the next IDLE cycle with a 1-cycle bubble.
- The counter saturates at IDLE_TIMEOUT and never wraps.
- The block applies no backpressure assumptions on uart_tx: i_tx_ready may drop the cycle after any accept.

Test Plan:
- Req0 sends 0x48,0x49(last) -> grant0 appears 1 cycle after valid; o_tx_data shows 0x48 then 0x49; o_busy falls the cycle after the 0x49 handshake.
- Req1 and req2 assert valid together from reset -> req1 granted first (priority starts at 0). After its last byte, req2 is granted even though req1 reasserts.
- Req0 locked mid-message (sent 0x41) while req3 valid with 0x5A -> req3 ready stays 0; no 0x5A appears on o_tx_data until req0's last byte.
- IDLE_TIMEOUT=8, req2 sends 1 byte without last, then drops valid -> release after exactly 8 idle cycles; pending req0 granted on the following IDLE cycle.
- Owner valid held high while i_tx_ready=0 for 50 cycles with IDLE_TIMEOUT=8 -> no release; byte transfers when ready rises.
- Assert i_rst_n=0 while LOCKED on req1 -> all outputs 0 immediately (asynchronously). After release, requester 0 has priority again.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx byte port between N_REQ requesters.
// A winner keeps the port until it sends a byte marked last or stays idle for IDLE_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TO_WIDTH     = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ*8-1:0]   i_req_data,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [N_REQ-1:0]     i_req_last,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = (TO_WIDTH < 1) ? 1 : TO_WIDTH;
    localparam logic TO_EN = (IDLE_TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LIMIT = CW'(IDLE_TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            own_valid_s;
    logic            own_last_s;
    logic            hs_s;
    logic            found_s;
    logic [OW-1:0]   pick_s;
    logic [CW-1:0]   cnt_inc_s;

    assign own_valid_s = i_req_valid[owner_q];
    assign own_last_s  = i_req_last[owner_q];
    assign hs_s        = own_valid_s & i_tx_ready;
    assign cnt_inc_s   = cnt_q + CW'(1'b1);

    // Round-robin pick: first valid requester after last_owner, wrapping.
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = last_owner_q;
        idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_owner_q) + i) % N_REQ;
            if (!found_s && i_req_valid[idx[OW-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx[OW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Lock/release decisions and the idle-timeout counter.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (found_s) begin
                    owner_d = pick_s;
                    state_d = ST_LOCKED;
                end else begin
                    owner_d = owner_q;
                end
            end
            ST_LOCKED: begin
                if (hs_s && own_last_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    cnt_d        = {CW{1'b0}};
                end else if (own_valid_s) begin
                    // waiting on uart_tx is not idleness
                    cnt_d = {CW{1'b0}};
                end else if (TO_EN && (cnt_inc_s >= TO_LIMIT)) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    cnt_d        = {CW{1'b0}};
                end else if (TO_EN) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = {CW{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, owner and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= {OW{1'b0}};
            last_owner_q <= OW'(N_REQ - 1);
            cnt_q        <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    // Owner's byte path is steered straight through to uart_tx while locked.
    always_comb begin
        o_grant     = {N_REQ{1'b0}};
        o_req_ready = {N_REQ{1'b0}};
        o_busy      = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        if (state_q == ST_LOCKED) begin
            o_grant              = N_REQ'(1'b1) << owner_q;
            o_req_ready[owner_q] = i_tx_ready;
            o_busy               = 1'b1;
            o_tx_valid           = own_valid_s;
            o_tx_data            = i_req_data[{owner_q, 3'b000} +: 8];
        end else begin
            o_busy = 1'b0;
        end
    end

endmodule
